// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA raster timing generator.
// Divides clk down to the pixel rate, runs the horizontal/vertical counters and
// produces registered hsync/vsync/video_on flags that are coherent with
// pixel_x/pixel_y in every clk cycle.
// Optional feature macro: VGA_SYNC_FRAME_EN adds frame_start / frame_count.

module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pixel_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync
`ifdef VGA_SYNC_FRAME_EN
    ,
    output logic       frame_start,
    output logic [7:0] frame_count
`endif
);

    // Raster geometry. Totals are at most 1024, so 10-bit counters suffice;
    // the sync window bounds may reach 1024 and are therefore compared in 11 bits.
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
    localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
    localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);

    // CLK_DIV is at most 16, so the divider fits in 4 bits.
    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0]  div_cnt;
    logic [3:0]  div_next;
    logic        tick_next;
    logic        x_wrap;
    logic        y_wrap;
    logic [9:0]  x_next;
    logic [9:0]  y_next;
    logic [10:0] x_ext;
    logic [10:0] y_ext;
    logic        video_next;
    logic        hsync_next;
    logic        vsync_next;

    // Next-state of divider and counters; flags are derived from the next-state
    // counters so that after the edge they describe the pixel then on display.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
        div_next   = div_cnt + 4'd1;
        x_next     = pixel_x;
        y_next     = pixel_y;

        if (div_cnt == DIV_LAST) begin
            div_next = '0;
        end

        // The tick is high exactly while div_cnt sits at its last value.
        tick_next = (div_next == DIV_LAST);

        // Counters move only at the end of a cycle in which pixel_tick is high.
        x_wrap = pixel_tick && (pixel_x == H_LAST);
        y_wrap = x_wrap && (pixel_y == V_LAST);

        if (pixel_tick) begin
            x_next = x_wrap ? 10'd0 : pixel_x + 10'd1;
        end
        if (x_wrap) begin
            y_next = y_wrap ? 10'd0 : pixel_y + 10'd1;
        end

        x_ext = {1'b0, x_next};
        y_ext = {1'b0, y_next};

        video_next = (x_ext < H_VIS) && (y_ext < V_VIS);
        hsync_next = !((x_ext >= HS_START) && (x_ext < HS_END));
        vsync_next = !((y_ext >= VS_START) && (y_ext < VS_END));
    end

    // Divider, counters and registered flags; async reset clears all of it at once.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every register samples the pre-edge values.
        if (reset) begin
            div_cnt    <= '0;
            pixel_tick <= 1'b0;
            pixel_x    <= '0;
            pixel_y    <= '0;
            video_on   <= 1'b0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
        end else begin
            div_cnt    <= div_next;
            pixel_tick <= tick_next;
            pixel_x    <= x_next;
            pixel_y    <= y_next;
            video_on   <= video_next;
            hsync      <= hsync_next;
            vsync      <= vsync_next;
        end
    end

`ifdef VGA_SYNC_FRAME_EN
    // Frame marker: raised on the edge of the (last,last)->(0,0) wrap, so it is
    // high in the first cycle showing (0,0) and never for the post-reset frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_start <= y_wrap;
            if (y_wrap) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen.
// Instance u_vga runs the default 640x480 timing with CLK_DIV=2; instance u_small
// runs a tiny 15x13 raster with CLK_DIV=1 so whole frames fit in a short run.
// Small raster: visible x<8, y<6; hsync low x=10..12; vsync low y=8..9.

module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       reset;

    logic       a_tick, a_video, a_hs, a_vs;
    logic [9:0] a_x, a_y;
    logic       b_tick, b_video, b_hs, b_vs;
    logic [9:0] b_x, b_y;
`ifdef VGA_SYNC_FRAME_EN
    logic       a_fs, b_fs;
    logic [7:0] a_fc, b_fc;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_sync_gen u_vga (
        .clk        (clk),
        .reset      (reset),
        .pixel_tick (a_tick),
        .pixel_x    (a_x),
        .pixel_y    (a_y),
        .video_on   (a_video),
        .hsync      (a_hs),
        .vsync      (a_vs)
`ifdef VGA_SYNC_FRAME_EN
        ,
        .frame_start(a_fs),
        .frame_count(a_fc)
`endif
    );

    vga_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .CLK_DIV  (1)
    ) u_small (
        .clk        (clk),
        .reset      (reset),
        .pixel_tick (b_tick),
        .pixel_x    (b_x),
        .pixel_y    (b_y),
        .video_on   (b_video),
        .hsync      (b_hs),
        .vsync      (b_vs)
`ifdef VGA_SYNC_FRAME_EN
        ,
        .frame_start(b_fs),
        .frame_count(b_fc)
`endif
    );

    // Called at a negedge: pulse reset for one cycle, release at the next negedge.
    task automatic restart();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reset values, then the first few edges after release.
    task automatic test_reset();
        n_vec++; if (a_tick !== 1'b0)  begin n_err++; $display("FAIL rst_tick: got %b expected 0", a_tick); end
        n_vec++; if (a_x !== 10'd0)    begin n_err++; $display("FAIL rst_x: got %0d expected 0", a_x); end
        n_vec++; if (a_y !== 10'd0)    begin n_err++; $display("FAIL rst_y: got %0d expected 0", a_y); end
        n_vec++; if (a_video !== 1'b0) begin n_err++; $display("FAIL rst_video: got %b expected 0", a_video); end
        n_vec++; if (a_hs !== 1'b1)    begin n_err++; $display("FAIL rst_hsync: got %b expected 1", a_hs); end
        n_vec++; if (a_vs !== 1'b1)    begin n_err++; $display("FAIL rst_vsync: got %b expected 1", a_vs); end
        n_vec++; if (b_tick !== 1'b0)  begin n_err++; $display("FAIL rst_small_tick: got %b expected 0", b_tick); end
`ifdef VGA_SYNC_FRAME_EN
        n_vec++; if (a_fs !== 1'b0)    begin n_err++; $display("FAIL rst_frame_start: got %b expected 0", a_fs); end
        n_vec++; if (a_fc !== 8'd0)    begin n_err++; $display("FAIL rst_frame_count: got %0d expected 0", a_fc); end
`endif
        reset = 1'b0;
        @(negedge clk); // after edge 1
        n_vec++; if (a_video !== 1'b1) begin n_err++; $display("FAIL e1_video: got %b expected 1", a_video); end
        n_vec++; if (a_tick !== 1'b1)  begin n_err++; $display("FAIL e1_tick: got %b expected 1", a_tick); end
        n_vec++; if (a_x !== 10'd0)    begin n_err++; $display("FAIL e1_x: got %0d expected 0", a_x); end
        n_vec++; if (b_tick !== 1'b1)  begin n_err++; $display("FAIL e1_small_tick: got %b expected 1", b_tick); end
        @(negedge clk); // after edge 2
        n_vec++; if (a_x !== 10'd1)    begin n_err++; $display("FAIL e2_x: got %0d expected 1", a_x); end
        n_vec++; if (a_tick !== 1'b0)  begin n_err++; $display("FAIL e2_tick: got %b expected 0", a_tick); end
        n_vec++; if (b_x !== 10'd1)    begin n_err++; $display("FAIL e2_small_x: got %0d expected 1", b_x); end
        @(negedge clk); // after edge 3
        n_vec++; if (a_x !== 10'd1)    begin n_err++; $display("FAIL e3_x: got %0d expected 1", a_x); end
        n_vec++; if (a_tick !== 1'b1)  begin n_err++; $display("FAIL e3_tick: got %b expected 1", a_tick); end
    endtask

    // Two full lines of the default raster: sync/blank windows and line length.
    task automatic test_line();
        int hs_low = 0, hs_first = -1, hs_last = -1;
        int vid_low = 0, vid_first = -1;
        int wrap1 = 0, wrap2 = 0, y1 = -1, y2 = -1;
        logic [9:0] prev_x;
        restart();
        prev_x = a_x;
        for (int k = 1; k <= 3201; k++) begin
            @(negedge clk);
            // Samples 2..1601 cover pixels 1..799 of line 0 plus pixel 0 of line 1.
            if (k >= 2 && k <= 1601) begin
                if (!a_hs) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = int'(a_x);
                    hs_last = int'(a_x);
                end
                if (!a_video) begin
                    vid_low++;
                    if (vid_first < 0) vid_first = int'(a_x);
                end
            end
            if (prev_x == 10'd799 && a_x == 10'd0) begin
                if (wrap1 == 0) begin wrap1 = k; y1 = int'(a_y); end
                else if (wrap2 == 0) begin wrap2 = k; y2 = int'(a_y); end
            end
            prev_x = a_x;
        end
        n_vec++; if (hs_low != 192)   begin n_err++; $display("FAIL hsync_low_clks: got %0d expected 192", hs_low); end
        n_vec++; if (hs_first != 656) begin n_err++; $display("FAIL hsync_first_x: got %0d expected 656", hs_first); end
        n_vec++; if (hs_last != 751)  begin n_err++; $display("FAIL hsync_last_x: got %0d expected 751", hs_last); end
        n_vec++; if (vid_low != 320)  begin n_err++; $display("FAIL blank_clks: got %0d expected 320", vid_low); end
        n_vec++; if (vid_first != 640) begin n_err++; $display("FAIL blank_first_x: got %0d expected 640", vid_first); end
        n_vec++; if (wrap1 != 1600)   begin n_err++; $display("FAIL first_wrap_clk: got %0d expected 1600", wrap1); end
        n_vec++; if (wrap2 - wrap1 != 1600) begin n_err++; $display("FAIL line_len: got %0d expected 1600", wrap2 - wrap1); end
        n_vec++; if (y1 != 1)         begin n_err++; $display("FAIL y_after_wrap1: got %0d expected 1", y1); end
        n_vec++; if (y2 != 2)         begin n_err++; $display("FAIL y_after_wrap2: got %0d expected 2", y2); end
    endtask

    // CLK_DIV=1: tick stuck high, x advances every clk, 15-clk lines.
    task automatic test_clk_div1();
        int tick_zero = 0, step_err = 0, wrap1 = 0, wrap2 = 0;
        int prev_x;
        restart();
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (b_tick !== 1'b1) tick_zero++;
            if (k >= 2) begin
                if (int'(b_x) != (prev_x + 1) % 15) step_err++;
                if (prev_x == 14 && b_x == 10'd0) begin
                    if (wrap1 == 0) wrap1 = k;
                    else if (wrap2 == 0) wrap2 = k;
                end
            end
            prev_x = int'(b_x);
        end
        n_vec++; if (tick_zero != 0) begin n_err++; $display("FAIL div1_tick_low: got %0d expected 0", tick_zero); end
        n_vec++; if (step_err != 0)  begin n_err++; $display("FAIL div1_x_step: got %0d expected 0", step_err); end
        n_vec++; if (wrap1 != 16)    begin n_err++; $display("FAIL div1_first_wrap: got %0d expected 16", wrap1); end
        n_vec++; if (wrap2 - wrap1 != 15) begin n_err++; $display("FAIL div1_line_len: got %0d expected 15", wrap2 - wrap1); end
    endtask

    // Small raster frames: vsync window, blanking, combined x/y wrap, frame length.
    task automatic test_frame();
        int vs_low = 0, vs_first_y = -1, vs_first_x = -1, vs_last_y = -1;
        int vid_low = 0, wrap1 = 0, wrap2 = 0, bad_y = 0;
        int pre_x = -1, pre_y = -1;
        logic [9:0] prev_x, prev_y;
        restart();
        prev_x = b_x;
        prev_y = b_y;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k <= 195) begin
                if (!b_vs) begin
                    vs_low++;
                    if (vs_first_y < 0) begin vs_first_y = int'(b_y); vs_first_x = int'(b_x); end
                    vs_last_y = int'(b_y);
                end
                if (!b_video) vid_low++;
            end
            if (b_y != prev_y && !(prev_x == 10'd14 && b_x == 10'd0)) bad_y++;
            if (k >= 2 && b_x == 10'd0 && b_y == 10'd0) begin
                if (wrap1 == 0) begin wrap1 = k; pre_x = int'(prev_x); pre_y = int'(prev_y); end
                else if (wrap2 == 0) wrap2 = k;
            end
            prev_x = b_x;
            prev_y = b_y;
        end
        n_vec++; if (vs_low != 30)    begin n_err++; $display("FAIL vsync_low_clks: got %0d expected 30", vs_low); end
        n_vec++; if (vs_first_y != 8) begin n_err++; $display("FAIL vsync_first_y: got %0d expected 8", vs_first_y); end
        n_vec++; if (vs_first_x != 0) begin n_err++; $display("FAIL vsync_first_x: got %0d expected 0", vs_first_x); end
        n_vec++; if (vs_last_y != 9)  begin n_err++; $display("FAIL vsync_last_y: got %0d expected 9", vs_last_y); end
        n_vec++; if (vid_low != 147)  begin n_err++; $display("FAIL frame_blank_clks: got %0d expected 147", vid_low); end
        n_vec++; if (bad_y != 0)      begin n_err++; $display("FAIL y_step_without_x_wrap: got %0d expected 0", bad_y); end
        n_vec++; if (pre_x != 14 || pre_y != 12) begin n_err++; $display("FAIL pre_wrap_xy: got (%0d,%0d) expected (14,12)", pre_x, pre_y); end
        n_vec++; if (wrap1 != 196)    begin n_err++; $display("FAIL first_frame_wrap: got %0d expected 196", wrap1); end
        n_vec++; if (wrap2 - wrap1 != 195) begin n_err++; $display("FAIL frame_len: got %0d expected 195", wrap2 - wrap1); end
    endtask

    // Reset asserted between clock edges must clear outputs immediately.
    task automatic test_mid_reset();
        // Default raster stopped at x=300 (edge 600).
        restart();
        repeat (600) @(negedge clk);
        n_vec++; if (a_x !== 10'd300) begin n_err++; $display("FAIL pre_reset_x: got %0d expected 300", a_x); end
        #2 reset = 1'b1;
        #1;
        n_vec++; if (a_x !== 10'd0 || a_y !== 10'd0) begin n_err++; $display("FAIL async_xy: got (%0d,%0d) expected (0,0)", a_x, a_y); end
        n_vec++; if (a_video !== 1'b0) begin n_err++; $display("FAIL async_video: got %b expected 0", a_video); end
        @(negedge clk);
        reset = 1'b0;
        // Small raster stopped at (11,8): both syncs low (edge 132).
        repeat (132) @(negedge clk);
        n_vec++; if (b_x !== 10'd11 || b_y !== 10'd8) begin n_err++; $display("FAIL pre_reset_small_xy: got (%0d,%0d) expected (11,8)", b_x, b_y); end
        n_vec++; if (b_hs !== 1'b0 || b_vs !== 1'b0) begin n_err++; $display("FAIL pre_reset_syncs: got %b%b expected 00", b_hs, b_vs); end
        #2 reset = 1'b1;
        #1;
        n_vec++; if (b_hs !== 1'b1 || b_vs !== 1'b1) begin n_err++; $display("FAIL async_syncs: got %b%b expected 11", b_hs, b_vs); end
        n_vec++; if (b_x !== 10'd0 || b_y !== 10'd0 || b_tick !== 1'b0) begin n_err++; $display("FAIL async_small: got x=%0d y=%0d tick=%b expected 0 0 0", b_x, b_y, b_tick); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_vec++; if (a_x !== 10'd0 || a_video !== 1'b1) begin n_err++; $display("FAIL restart_a: got x=%0d video=%b expected 0 1", a_x, a_video); end
        n_vec++; if (b_x !== 10'd0 || b_y !== 10'd0) begin n_err++; $display("FAIL restart_b: got (%0d,%0d) expected (0,0)", b_x, b_y); end
    endtask

`ifdef VGA_SYNC_FRAME_EN
    // 256 small frames: pulse position, width, count sequence and 8-bit wrap.
    task automatic test_frame_count();
        int pulses = 0, first_k = 0, second_k = 0, wide = 0;
        int fc1 = -1, fc2 = -1, fc255 = -1, fc256 = -1;
        logic prev_fs = 1'b0;
        restart();
        for (int k = 1; k <= 52000 && pulses < 256; k++) begin
            @(negedge clk);
            if (b_fs) begin
                if (prev_fs) wide++;
                pulses++;
                if (pulses == 1)   begin first_k = k; fc1 = int'(b_fc); end
                if (pulses == 2)   begin second_k = k; fc2 = int'(b_fc); end
                if (pulses == 255) fc255 = int'(b_fc);
                if (pulses == 256) fc256 = int'(b_fc);
            end
            prev_fs = b_fs;
        end
        n_vec++; if (first_k != 196)  begin n_err++; $display("FAIL first_pulse_clk: got %0d expected 196", first_k); end
        n_vec++; if (second_k - first_k != 195) begin n_err++; $display("FAIL pulse_period: got %0d expected 195", second_k - first_k); end
        n_vec++; if (wide != 0)       begin n_err++; $display("FAIL pulse_width: got %0d wide expected 0", wide); end
        n_vec++; if (fc1 != 1 || fc2 != 2) begin n_err++; $display("FAIL count_seq: got %0d,%0d expected 1,2", fc1, fc2); end
        n_vec++; if (fc255 != 255)    begin n_err++; $display("FAIL count_255: got %0d expected 255", fc255); end
        n_vec++; if (fc256 != 0)      begin n_err++; $display("FAIL count_wrap: got %0d expected 0 (pulses %0d)", fc256, pulses); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_line();
        test_clk_div1();
        test_frame();
        test_mid_reset();
`ifdef VGA_SYNC_FRAME_EN
        test_frame_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
